// File: rtl/tlc_phase_sched.sv
// Demand-driven phase scheduler for a main/side intersection with a pedestrian walk phase.
// Durations are counted in effective timebase ticks (tick & !hold).
module tlc_phase_sched #(
  parameter int TW     = 8,
  parameter int G_MIN  = 4,
  parameter int G_MAX  = 8,
  parameter int Y_T    = 2,
  parameter int AR_T   = 1,
  parameter int WALK_T = 3
) (
  input  logic       c,
  input  logic       r_n,
  input  logic       tick,
  input  logic       hold,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_col,
  output logic [2:0] side_col,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_SG  = 3'd3,
    S_SY  = 3'd4,
    S_AR2 = 3'd5,
    S_PW  = 3'd6
  } state_t;

  localparam logic [TW-1:0] L_GMIN_END = TW'(G_MIN - 1);
  localparam logic [TW-1:0] L_GMAX_END = TW'(G_MAX - 1);
  localparam logic [TW-1:0] L_Y_END    = TW'(Y_T - 1);
  localparam logic [TW-1:0] L_AR_END   = TW'(AR_T - 1);
  localparam logic [TW-1:0] L_WALK_END = TW'(WALK_T - 1);

  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b100;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_el;
  logic          r_pp;
  logic          w_eff;
  logic          w_change;
  logic          w_min_done;

  assign w_eff      = tick & ~hold;
  assign w_change   = (w_next != r_state);
  assign w_min_done = (r_el >= L_GMIN_END);

  // Transitions happen only on effective ticks; the unused code 7 recovers to MG unconditionally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MG:  if (w_eff && w_min_done && (car_side || r_pp)) w_next = S_MY;
      S_MY:  if (w_eff && (r_el == L_Y_END)) w_next = S_AR1;
      S_AR1: if (w_eff && (r_el == L_AR_END)) w_next = r_pp ? S_PW : S_SG;
      S_SG:  if (w_eff && ((r_el == L_GMAX_END) || (w_min_done && !car_side))) w_next = S_SY;
      S_SY:  if (w_eff && (r_el == L_Y_END)) w_next = S_AR2;
      S_AR2: if (w_eff && (r_el == L_AR_END)) w_next = r_pp ? S_PW : S_MG;
      S_PW:  if (w_eff && (r_el == L_WALK_END)) w_next = car_side ? S_SG : S_MG;
      default: w_next = S_MG;
    endcase
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      r_state <= S_MG;
    end else begin
      r_state <= w_next;
    end
  end

  // MG may rest forever without demand, so its count parks at the minimum-green mark.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      r_el <= '0;
    end else if (w_change) begin
      r_el <= '0;
    end else if (w_eff) begin
      if (r_state == S_MG) begin
        if (r_el < L_GMIN_END) r_el <= r_el + TW'(1);
      end else begin
        r_el <= r_el + TW'(1);
      end
    end
  end

  // Entering the walk phase serves the request, even one arriving on that same edge.
  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      r_pp <= 1'b0;
    end else if (w_change && (w_next == S_PW)) begin
      r_pp <= 1'b0;
    end else if (ped_req) begin
      r_pp <= 1'b1;
    end
  end

  always_comb begin
    main_col = L_RED;
    side_col = L_RED;
    walk     = 1'b0;
    case (r_state)
      S_MG: main_col = L_GREEN;
      S_MY: main_col = L_YELLOW;
      S_SG: side_col = L_GREEN;
      S_SY: side_col = L_YELLOW;
      S_PW: walk     = 1'b1;
      default: ;
    endcase
  end

  assign phase = r_state;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed bench for tlc_phase_sched: phase durations, demand handling, hold and async reset.
module tb_tlc_phase_sched;

  logic       c;
  logic       r_n;
  logic       tick;
  logic       hold;
  logic       car_side;
  logic       ped_req;
  logic [2:0] main_col;
  logic [2:0] side_col;
  logic       walk;
  logic [2:0] phase;

  int numAsserts = 0;
  int numFails   = 0;

  localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_AR1 = 3'd2, P_SG = 3'd3,
                         P_SY = 3'd4, P_AR2 = 3'd5, P_PW = 3'd6;

  tlc_phase_sched dut (
    .c        (c),
    .r_n      (r_n),
    .tick     (tick),
    .hold     (hold),
    .car_side (car_side),
    .ped_req  (ped_req),
    .main_col (main_col),
    .side_col (side_col),
    .walk     (walk),
    .phase    (phase)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  function automatic logic [2:0] expMain(input logic [2:0] p);
    case (p)
      P_MG:    return 3'b001;
      P_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] expSide(input logic [2:0] p);
    case (p)
      P_SG:    return 3'b001;
      P_SY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    numAsserts++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  // Expect phase p with its decoded heads for n consecutive cycles, advancing one clock per cycle.
  task automatic expectPhase(input string tag, input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".phase"}, {5'd0, phase}, {5'd0, p});
      checkOutput({tag, ".main"}, {5'd0, main_col}, {5'd0, expMain(p)});
      checkOutput({tag, ".side"}, {5'd0, side_col}, {5'd0, expSide(p)});
      checkOutput({tag, ".walk"}, {7'd0, walk}, {7'd0, (p == P_PW)});
      step();
    end
  endtask

  task automatic applyStimulus();
    r_n      = 1'b0;
    tick     = 1'b1;
    hold     = 1'b0;
    car_side = 1'b0;
    ped_req  = 1'b0;
    step();
    step();
    r_n = 1'b1;
  endtask

  initial begin
    // Idle: no demand keeps MG indefinitely
    applyStimulus();
    checkOutput("rst.pp", {7'd0, dut.r_pp}, 8'd0);
    expectPhase("idle", P_MG, 20);

    // Side demand held high: side green maxes out at G_MAX
    applyStimulus();
    car_side = 1'b1;
    expectPhase("max.mg", P_MG, 4);
    expectPhase("max.my", P_MY, 2);
    expectPhase("max.ar1", P_AR1, 1);
    expectPhase("max.sg", P_SG, 8);
    expectPhase("max.sy", P_SY, 2);
    expectPhase("max.ar2", P_AR2, 1);
    expectPhase("max.mg2", P_MG, 4);
    expectPhase("max.my2", P_MY, 1);

    // Side demand drops on the 2nd SG cycle: side green ends at G_MIN
    applyStimulus();
    car_side = 1'b1;
    expectPhase("min.mg", P_MG, 4);
    expectPhase("min.my", P_MY, 2);
    expectPhase("min.ar1", P_AR1, 1);
    expectPhase("min.sg1", P_SG, 1);
    car_side = 1'b0;
    expectPhase("min.sg", P_SG, 3);
    expectPhase("min.sy", P_SY, 2);
    expectPhase("min.ar2", P_AR2, 1);
    expectPhase("min.rest", P_MG, 6);

    // Single pedestrian pulse at cycle 1 with no side demand
    applyStimulus();
    expectPhase("ped.mg0", P_MG, 1);
    ped_req = 1'b1;
    expectPhase("ped.mg1", P_MG, 1);
    ped_req = 1'b0;
    checkOutput("ped.pp_set", {7'd0, dut.r_pp}, 8'd1);
    expectPhase("ped.mg", P_MG, 2);
    expectPhase("ped.my", P_MY, 2);
    expectPhase("ped.ar1", P_AR1, 1);
    checkOutput("ped.pp_clr", {7'd0, dut.r_pp}, 8'd0);
    expectPhase("ped.pw", P_PW, 3);
    expectPhase("ped.rest", P_MG, 6);

    // Hold for 5 cycles from the 1st MY cycle; a request during hold is still latched
    applyStimulus();
    car_side = 1'b1;
    expectPhase("hold.mg", P_MG, 4);
    hold = 1'b1;
    ped_req = 1'b1;
    expectPhase("hold.frz0", P_MY, 1);
    ped_req = 1'b0;
    expectPhase("hold.frz", P_MY, 4);
    hold = 1'b0;
    expectPhase("hold.my", P_MY, 2);
    expectPhase("hold.ar1", P_AR1, 1);
    expectPhase("hold.pw", P_PW, 3);
    expectPhase("hold.sg", P_SG, 1);

    // Async reset mid side-green, asserted between clock edges
    applyStimulus();
    car_side = 1'b1;
    expectPhase("arst.mg", P_MG, 4);
    expectPhase("arst.my", P_MY, 2);
    expectPhase("arst.ar1", P_AR1, 1);
    ped_req = 1'b1;
    expectPhase("arst.sg1", P_SG, 1);
    ped_req = 1'b0;
    expectPhase("arst.sg2", P_SG, 1);
    checkOutput("arst.pp_pre", {7'd0, dut.r_pp}, 8'd1);
    #2;
    r_n = 1'b0;
    #1;
    checkOutput("arst.phase", {5'd0, phase}, 8'd0);
    checkOutput("arst.main", {5'd0, main_col}, 8'h01);
    checkOutput("arst.side", {5'd0, side_col}, 8'h04);
    checkOutput("arst.walk", {7'd0, walk}, 8'd0);
    checkOutput("arst.pp", {7'd0, dut.r_pp}, 8'd0);
    step();
    r_n = 1'b1;
    car_side = 1'b0;
    expectPhase("arst.after", P_MG, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule

// File: doc/tlc_phase_sched.md
# tlc_phase_sched

Demand-driven phase scheduler for a two-approach intersection (main road, side road) with a pedestrian walk phase. It advances through green/yellow/all-red phases using programmable durations counted in timebase ticks. It sequences the per-approach signal heads and walk lamp, and resolves competing side-road and pedestrian demand. It sits above the per-head colour decode and below any supervisory override logic.

## Interface
- TW, 8: tick-counter width; every duration must be < 2^TW
- G_MIN, 4: minimum green, both approaches (ticks, ≥1)
- G_MAX, 8: maximum side green (ticks, ≥G_MIN)
- Y_T, 2: yellow duration (ticks, ≥1)
- AR_T, 1: all-red clearance (ticks, ≥1)
- WALK_T, 3: pedestrian walk duration (ticks, ≥1)

Ports:
- c  in  1  clock, rising edge
- r_n  in  1  reset, asynchronous, active-low
- tick  in  1  timebase enable, 1-cycle pulse; all timing counts ticks
- hold  in  1  freeze: while 1, ticks are ignored (timer and state frozen)
- car_side  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian request, pulse or level
- main_col  out  3  main head, one-hot: bit0 green, bit1 yellow, bit2 red
- side_col  out  3  side head, same encoding
- walk  out  1  walk lamp
- phase  out  3  current state code

## Operation
- States and codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, PW=6. Codes 7 → MG on the next clock.
- Decode from the state register only:
  - MG: main=001, side=100.
  - MY: main=010, side=100.
  - SG: main=100, side=001.
  - SY: main=100, side=010.
  - AR1/AR2/PW: both 100.
  - walk=1 only in PW.
- Elapsed counter `el` (TW bits):
  - Cleared to 0 on every state change.
  - Increments on each effective tick (tick & !hold) that does not change state.
  - "Tick k of a state" means el==k-1 at that tick.
- Pedestrian pending flag `pp`:
  - Set when ped_req=1 on any clock.
  - Cleared on the clock that enters PW. If ped_req=1 on that same clock, clear wins.
- Transitions are evaluated only on effective ticks:
  - MG → MY when el ≥ G_MIN-1 and (car_side | pp). With no demand, MG rests indefinitely and el saturates at G_MIN-1.
  - MY → AR1 when el == Y_T-1.
  - AR1 → PW if pp, else SG, when el == AR_T-1.
  - SG → SY when el == G_MAX-1, or when el ≥ G_MIN-1 and car_side=0.
  - SY → AR2 when el == Y_T-1.
  - AR2 → PW if pp, else MG, when el == AR_T-1.
  - PW → SG if car_side, else MG, when el == WALK_T-1.
- Side green entered with car_side already low still runs the full G_MIN.
- Reset values: state MG, el 0, pp 0, main_col 001, side_col 100, walk 0, phase 0.

## Timing
- Each state lasts exactly N effective ticks, where N is its parameter. MG and SG use their rules above.
- A transition takes effect on the clock edge that samples the qualifying tick. Outputs change on that same edge (Moore, no extra latency).
- car_side and pp are sampled on the deciding tick only.
- A ped_req arriving on the deciding tick of MG counts as demand only from the next tick, because pp is registered.
- hold=1 with tick=1: no increment, no transition. ped_req is still latched during hold.
- r_n low at any time, mid-phase included, forces reset values immediately, without waiting for a clock edge. Release is synchronous to c.
- Yellow always precedes red; all-red always separates conflicting greens. PW is entered only from an all-red state.

## Test plan
Default parameters, tick=1 every cycle unless stated.

- Reset, no demand, 20 cycles → phase stays 0, main_col=001, side_col=100, walk=0.
- car_side held high from cycle 0 → MG 4, MY 2, AR1 1, SG 8 (max-out), SY 2, AR2 1, then MG again. Check each state's cycle count.
- car_side high, dropped on the 2nd SG cycle → SG lasts exactly 4 cycles (min), then SY.
- Single ped_req pulse at cycle 1, car_side=0 → MG 4, MY 2, AR1 1, PW 3 (walk=1, both heads 100), then MG. pp is 0 after PW entry.
- car_side high, hold=1 for 5 cycles starting at the 1st MY cycle → main_col=010 throughout the hold. MY then still totals 2 effective ticks.
- r_n pulled low during the 3rd SG cycle, between clock edges → outputs 001/100, walk 0, phase 0 before the next edge. pp is cleared.
